// File: rtl/rns_fwd_conv.sv
// Forward RNS converter: binary X -> residues mod {255, 256, 257, 511}, one byte per cycle, MSB first.
// Optional macro RNS_SIGNED_EN treats X as two's complement and corrects the final residues.
//
// state  | meaning
// IDLE   | waiting for an operand, IN_READY=1
// CONV   | consuming one byte per cycle through the Horner accumulators
// DONE   | result held on R1..R4 with OUT_VALID=1 until OUT_READY
module rns_fwd_conv #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] X,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [7:0]        R1,
    output logic [7:0]        R2,
    output logic [8:0]        R3,
    output logic [8:0]        R4,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(NB + 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        a255_q, a255_d;
    logic [7:0]        a256_q, a256_d;
    logic [8:0]        a257_q, a257_d;
    logic [8:0]        a511_q, a511_d;
    logic [7:0]        r1_q, r1_d;
    logic [7:0]        r2_q, r2_d;
    logic [8:0]        r3_q, r3_d;
    logic [8:0]        r4_q, r4_d;

    logic [7:0]        b;
    logic [9:0]        s255, e255, d257, s511, e511;
    logic [7:0]        n255;
    logic [8:0]        n257, n511;
    logic [7:0]        f255;
    logic [8:0]        f257, f511;

    // 256 = 1 (mod 255), -1 (mod 257), and rotl9 by 8 (mod 511)
    always_comb begin
        b    = shift_q[DATA_W-1 -: 8];
        s255 = {2'b00, a255_q} + {2'b00, b};
        e255 = {2'b00, s255[7:0]} + {8'd0, s255[9:8]};
        n255 = (e255 == 10'd255) ? 8'd0 : e255[7:0];
        d257 = {2'b00, b} + 10'd257 - {1'b0, a257_q};
        if (d257 >= 10'd257) begin
            d257 = d257 - 10'd257;
        end
        n257 = d257[8:0];
        s511 = {1'b0, a511_q[0], a511_q[8:1]} + {2'b00, b};
        e511 = {1'b0, s511[8:0]} + {9'd0, s511[9]};
        n511 = (e511 == 10'd511) ? 9'd0 : e511[8:0];
    end

`ifdef RNS_SIGNED_EN
    function automatic int pow2_mod(input int w, input int m);
        int r;
        r = 1;
        for (int i = 0; i < w; i++) begin
            r = (r * 2) % m;
        end
        return r;
    endfunction

    localparam int C255 = pow2_mod(DATA_W, 255);
    localparam int C257 = pow2_mod(DATA_W, 257);
    localparam int C511 = pow2_mod(DATA_W, 511);

    logic       sign_q, sign_d;
    logic [9:0] t255, t257, t511;

    always_comb begin
        sign_d = sign_q;
        if (state_q == S_IDLE && IN_VALID) begin
            sign_d = X[DATA_W-1];
        end
        t255 = {2'b00, n255} + 10'd255 - 10'(C255);
        if (t255 >= 10'd255) t255 = t255 - 10'd255;
        t257 = {1'b0, n257} + 10'd257 - 10'(C257);
        if (t257 >= 10'd257) t257 = t257 - 10'd257;
        t511 = {1'b0, n511} + 10'd511 - 10'(C511);
        if (t511 >= 10'd511) t511 = t511 - 10'd511;
        f255 = n255;
        f257 = n257;
        f511 = n511;
        // 2^DATA_W is a multiple of 256, so R2 never needs correcting
        if (sign_q) begin
            f255 = t255[7:0];
            f257 = t257[8:0];
            f511 = t511[8:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sign_q <= 1'b0;
        else     sign_q <= sign_d;
    end
`else
    always_comb begin
        f255 = n255;
        f257 = n257;
        f511 = n511;
    end
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        a255_d  = a255_q;
        a256_d  = a256_q;
        a257_d  = a257_q;
        a511_d  = a511_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        r4_d    = r4_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    shift_d = X;
                    cnt_d   = '0;
                    a255_d  = '0;
                    a256_d  = '0;
                    a257_d  = '0;
                    a511_d  = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                shift_d = shift_q << 8;
                cnt_d   = cnt_q + CNT_W'(1);
                a255_d  = n255;
                a256_d  = b;
                a257_d  = n257;
                a511_d  = n511;
                if (cnt_q == CNT_W'(NB - 1)) begin
                    r1_d    = f255;
                    r2_d    = b;
                    r3_d    = f257;
                    r4_d    = f511;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (OUT_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            a255_q  <= '0;
            a256_q  <= '0;
            a257_q  <= '0;
            a511_q  <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            r4_q    <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            a255_q  <= a255_d;
            a256_q  <= a256_d;
            a257_q  <= a257_d;
            a511_q  <= a511_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            r4_q    <= r4_d;
        end
    end

    assign IN_READY  = (state_q == S_IDLE);
    assign OUT_VALID = (state_q == S_DONE);
    assign R1 = r1_q;
    assign R2 = r2_q;
    assign R3 = r3_q;
    assign R4 = r4_q;

endmodule
